// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions. Holds the receiver state encoding
//                and the default frame geometry used by uart_tx, uart_rx and
//                the baud generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Default frame geometry shared across the UART blocks
   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

   // Receiver states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : Two-flop synchronizer for a single asynchronous input.
//                Both stages reset to RST_VAL so an idle line does not look
//                like activity coming out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,   // active-low, synchronous
   input  logic d,
   output logic q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   // Next values: plain two-stage shift
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer stages with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver (8N1 by default). Validates the
//                start bit at mid-bit, shifts data LSB-first, checks the stop
//                bit and reports each byte with a one-cycle rx_valid pulse.
//                A low stop bit pulses frame_err and parks in BREAK until the
//                line returns high.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int DATA_BITS  = uart_pkg::DEF_DATA_BITS,
   parameter int OVERSAMPLE = uart_pkg::DEF_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst,        // active-low, synchronous
   input  logic                 os_tick,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 frame_err
);

   import uart_pkg::*;

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Mid-start check point and end-of-bit point (sampling lands mid-bit
   // because the bit grid is offset by half a bit from the start edge)
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;

   uart_rx_state_e       state_d,     state_q;
   logic [CNT_W-1:0]     cnt_d,       cnt_q;
   logic [IDX_W-1:0]     bit_idx_d,   bit_idx_q;
   logic [DATA_BITS-1:0] shift_d,     shift_q;
   logic [DATA_BITS-1:0] rx_data_d,   rx_data_q;
   logic                 rx_valid_d,  rx_valid_q;
   logic                 frame_err_d, frame_err_q;

   uart_sync #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_serial),
      .q   (rx_s)
   );

   // Next-state, counters, shift register and output pulses
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      if (os_tick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end

            START: begin
               if (cnt_q == CNT_MID) begin
                  cnt_d = '0;
                  if (!rx_s) begin
                     state_d   = DATA;
                     bit_idx_d = '0;
                  end else begin
                     // Line came back high before mid-start: a glitch
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            DATA: begin
               if (cnt_q == CNT_END) begin
                  cnt_d   = '0;
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_idx_q == IDX_LAST) begin
                     state_d = STOP;
                  end else begin
                     bit_idx_d = bit_idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            STOP: begin
               if (cnt_q == CNT_END) begin
                  cnt_d = '0;
                  if (rx_s) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = BREAK;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            BREAK: begin
               // Hold off until the line is released so a long low level
               // cannot retrigger frames
               if (rx_s) begin
                  state_d = IDLE;
               end
            end

            default: begin
               state_d   = IDLE;
               cnt_d     = '0;
               bit_idx_d = '0;
            end
         endcase
      end
   end

   // State and datapath registers; reset discards any frame in progress
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign rx_busy   = (state_q != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A table of single frames is
//                applied in a loop, followed by hand-written sequences for
//                back-to-back frames, start glitch, break, mid-frame reset and
//                os_tick stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int OS = 16;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_valid;
      int         exp_err;
      logic [7:0] exp_data;
   } vec_t;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic       os_tick   = 1'b0;
   logic       rx_serial = 1'b1;
   logic       stall     = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;

   int checks    = 0;
   int failures  = 0;
   int tick_cnt  = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   int div_cnt   = 0;

   logic [7:0] data_q[$];
   int         stamp_q[$];

   vec_t vecs[5];

   uart_rx #(
      .DATA_BITS  (8),
      .OVERSAMPLE (OS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .os_tick   (os_tick),
      .rx_serial (rx_serial),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_busy   (rx_busy),
      .frame_err (frame_err)
   );

   // Clock
   initial forever #5 clk = ~clk;

   // One os_tick every 4 clk, suppressed while stalled
   initial forever begin
      @(negedge clk);
      os_tick = (div_cnt == 3) && !stall;
      div_cnt = (div_cnt + 1) % 4;
   end

   // Output monitor: counts ticks, records valid bytes with tick stamps
   initial forever begin
      @(posedge clk);
      if (os_tick) tick_cnt++;
      #1;
      if (rx_valid) begin
         valid_cnt++;
         data_q.push_back(rx_data);
         stamp_q.push_back(tick_cnt);
      end
      if (frame_err) err_cnt++;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!os_tick) @(posedge clk);
      end
      @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      rx_serial = b;
      wait_ticks(OS);
   endtask

   // Start, 8 data bits LSB-first, one stop bit; line is left at stop level
   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   initial begin
      int nv;
      int ne;
      int n;
      logic [7:0] d99;

      vecs[0] = '{data: 8'h41, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'h41};
      vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'h00};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'hFF};
      vecs[3] = '{data: 8'h0F, stop: 1'b0, exp_valid: 0, exp_err: 1, exp_data: 8'hFF};
      vecs[4] = '{data: 8'h80, stop: 1'b1, exp_valid: 1, exp_err: 0, exp_data: 8'h80};

      // Reset state
      repeat (4) @(negedge clk);
      check("reset_rx_data",   int'(rx_data),   0);
      check("reset_rx_valid",  int'(rx_valid),  0);
      check("reset_rx_busy",   int'(rx_busy),   0);
      check("reset_frame_err", int'(frame_err), 0);
      rst = 1'b1;
      wait_ticks(4);

      // Single-frame vector table
      for (int v = 0; v < 5; v++) begin
         nv = valid_cnt;
         ne = err_cnt;
         send_frame(vecs[v].data, vecs[v].stop);
         rx_serial = 1'b1;
         wait_ticks(OS);
         check($sformatf("vec%0d_valid_cnt", v), valid_cnt - nv, vecs[v].exp_valid);
         check($sformatf("vec%0d_err_cnt", v),   err_cnt - ne,   vecs[v].exp_err);
         check($sformatf("vec%0d_rx_data", v),   int'(rx_data),  int'(vecs[v].exp_data));
         check($sformatf("vec%0d_busy", v),      int'(rx_busy),  0);
         if (vecs[v].exp_valid == 1)
            check($sformatf("vec%0d_last_byte", v),
                  int'(data_q[data_q.size()-1]), int'(vecs[v].exp_data));
      end

      // Back-to-back frames with a single stop bit
      data_q.delete();
      stamp_q.delete();
      ne = err_cnt;
      send_frame(8'h42, 1'b1);
      send_frame(8'h55, 1'b1);
      wait_ticks(OS);
      n = data_q.size();
      check("b2b_count", n, 2);
      check("b2b_byte0", (n > 0) ? int'(data_q[0]) : -1, 8'h42);
      check("b2b_byte1", (n > 1) ? int'(data_q[1]) : -1, 8'h55);
      check("b2b_spacing", (n > 1) ? (stamp_q[1] - stamp_q[0]) : -1, 160);
      check("b2b_err", err_cnt - ne, 0);

      // Start glitch of 4 ticks
      nv = valid_cnt;
      ne = err_cnt;
      rx_serial = 1'b0;
      wait_ticks(4);
      rx_serial = 1'b1;
      wait_ticks(4);
      check("glitch_busy_mid", int'(rx_busy), 1);
      wait_ticks(4);
      check("glitch_busy_end", int'(rx_busy), 0);
      wait_ticks(8);
      check("glitch_valid", valid_cnt - nv, 0);
      check("glitch_err",   err_cnt - ne,   0);

      // Bad stop bit followed by a long break
      nv = valid_cnt;
      ne = err_cnt;
      send_frame(8'hA5, 1'b0);
      wait_ticks(40 * OS);
      check("break_err_cnt", err_cnt - ne,   1);
      check("break_valid",   valid_cnt - nv, 0);
      check("break_rx_data", int'(rx_data),  8'h55);
      check("break_busy",    int'(rx_busy),  1);
      rx_serial = 1'b1;
      wait_ticks(OS);
      check("break_release_busy", int'(rx_busy), 0);
      nv = valid_cnt;
      send_frame(8'h3C, 1'b1);
      wait_ticks(OS);
      check("after_break_valid", valid_cnt - nv, 1);
      check("after_break_data",  int'(rx_data),  8'h3C);

      // Reset in the middle of data bit 3; the sender then aborts
      nv  = valid_cnt;
      ne  = err_cnt;
      d99 = 8'h99;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d99[i]);
      rx_serial = d99[3];
      wait_ticks(OS / 2);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_rx_data",   int'(rx_data),   0);
      check("midrst_rx_valid",  int'(rx_valid),  0);
      check("midrst_rx_busy",   int'(rx_busy),   0);
      check("midrst_frame_err", int'(frame_err), 0);
      rst       = 1'b1;
      rx_serial = 1'b1;
      wait_ticks(20 * OS);
      check("midrst_no_valid", valid_cnt - nv, 0);
      check("midrst_no_err",   err_cnt - ne,   0);
      nv = valid_cnt;
      send_frame(8'hFF, 1'b1);
      wait_ticks(OS);
      check("post_rst_valid", valid_cnt - nv, 1);
      check("post_rst_data",  int'(rx_data),  8'hFF);

      // os_tick stalled for 100 clk mid-frame
      nv = valid_cnt;
      ne = err_cnt;
      fork
         send_frame(8'h7E, 1'b1);
         begin
            repeat (200) @(negedge clk);
            stall = 1'b1;
            repeat (100) @(negedge clk);
            stall = 1'b0;
         end
      join
      rx_serial = 1'b1;
      wait_ticks(OS);
      check("stall_valid", valid_cnt - nv, 1);
      check("stall_data",  int'(rx_data),  8'h7E);
      check("stall_err",   err_cnt - ne,   0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream partner of uart_tx. It consumes the serial line uart_tx drives on tx_serial, or an external RX pin.
- Oversamples the line using a 16x-baud tick, validates the start bit, shifts in 8N1 data LSB-first and checks the stop bit.
- Presents each received byte with a one-cycle valid pulse to the host side. Flags framing errors.

Parameters:
- DATA_BITS, 8: data bits per frame; supported range 5..8.
- OVERSAMPLE, 16: os_tick pulses per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; active-low, synchronous (sampled on the rising edge of clk).
- os_tick  input  1  single-cycle pulse at OVERSAMPLE x baud rate.
- rx_serial  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; rx_data is new this cycle.
- rx_busy  output  1  high while a frame is in progress (state is not IDLE).
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Synchronizer: rx_serial passes through 2 flops, both reset to 1, giving rx_s. All decisions use rx_s.
- Reset (rst==0 at posedge clk):
  - state=IDLE.
  - rx_data=0, rx_valid=0, frame_err=0, rx_busy=0.
  - Tick counter and bit index are cleared.
  - Reset takes priority over everything. A frame in progress is discarded silently, with no rx_valid and no frame_err.
- All state and counter updates happen only in cycles with os_tick=1. Without os_tick, every register holds. rx_valid and frame_err are the only exception: they always self-clear after one clk.
- IDLE:
  - os_tick && rx_s==0 -> START, cnt=0.
- START (mid-bit validation):
  - On each os_tick, cnt++.
  - At cnt==OVERSAMPLE/2-1 (the 8th tick), check rx_s:
    - rx_s==0 -> DATA, cnt=0, bit_idx=0.
    - rx_s==1 -> IDLE. The start was a glitch; nothing is reported.
- DATA:
  - On each os_tick, cnt++.
  - At cnt==OVERSAMPLE-1:
    - Shift rx_s into the MSB of the shift register (shift right, LSB-first) and set cnt=0.
    - If bit_idx==DATA_BITS-1 -> STOP; else bit_idx++.
  - Sampling therefore falls at mid-bit.
- STOP:
  - At cnt==OVERSAMPLE-1, check rx_s:
    - rx_s==1: load rx_data from the shift register, pulse rx_valid, go to IDLE.
    - rx_s==0: pulse frame_err, leave rx_data unchanged, go to BREAK.
  - The block returns to IDLE at mid-stop-bit so the next start edge is caught with half a bit of margin.
- BREAK:
  - os_tick && rx_s==1 -> IDLE.
  - This stops a held-low line (break) from retriggering frames.
- rx_busy = (state != IDLE). It is registered/decoded from state, with no extra latency beyond the state register.
- Latency: rx_valid rises on the clk edge of the os_tick that samples mid-stop. That is OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE os_ticks after start detection, i.e. 152 ticks for the defaults. Add 2 clk of synchronizer delay.
- Back-to-back frames with exactly one stop bit must be received without loss.
- There is no flow control. A new byte overwrites rx_data; the host must capture it on rx_valid.
- Unknown or illegal state encoding -> IDLE.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams: IDLE, START, DATA, STOP, BREAK.
  - Default OVERSAMPLE=16 and DATA_BITS=8, shared with uart_tx and the baud generator.
- One sub-module: uart_sync, a 2-flop synchronizer.
  - Ports: clk, rst, d, q.
  - Reset value is a parameter; uart_rx uses 1.
  - Reusable for other async inputs.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
1. Drive 0x41 as 8N1 at 16 os_ticks/bit, with os_tick every 4 clk -> exactly one rx_valid pulse, rx_data=0x41, frame_err never 1, rx_busy low afterwards.
2. Send 0x42 then 0x55 back-to-back with a single stop bit -> two rx_valid pulses, 160 ticks apart, carrying 0x42 then 0x55.
3. Glitch: rx_serial low for 4 os_ticks, then high -> no rx_valid and no frame_err; rx_busy deasserts at the 8th tick.
4. Send 0xA5 with stop=0, then hold the line low for 40 bit times -> one frame_err pulse, rx_valid 0, rx_data keeps its previous value, no further pulses. Release high, then send 0x3C -> rx_valid with 0x3C.
5. Assert rst=0 for 1 clk during data bit 3 of 0x99 -> all outputs read 0 on the next clk and no rx_valid for that frame. A following 0xFF frame decodes correctly.
6. Stall os_tick for 100 clk in mid-frame while sending 0x7E -> the frame still decodes to 0x7E with one rx_valid pulse.
